// File: rtl/sfx_pkg.sv
// ============================================================================
//  Module   : sfx_pkg
//  Purpose  : Shared effect IDs, sequencer state encoding and note ROM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sfx_pkg;

   localparam logic [1:0] SFX_NONE   = 2'd0;
   localparam logic [1:0] SFX_SHEEP  = 2'd1;
   localparam logic [1:0] SFX_SWORD  = 2'd2;
   localparam logic [1:0] SFX_PLAYER = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } sfx_state_t;

   typedef struct packed {
      logic [7:0] per;
      logic [3:0] dur;
   } sfx_note_t;

   // A duration of zero marks the end of an effect.
   function automatic sfx_note_t sfx_note(input logic [1:0] effect_id,
                                          input logic [1:0] index);
      sfx_note_t n;
      n = '{per: 8'h00, dur: 4'd0};
      case ({effect_id, index})
         {SFX_SHEEP,  2'd0}: n = '{per: 8'h40, dur: 4'd3};
         {SFX_SHEEP,  2'd1}: n = '{per: 8'h30, dur: 4'd3};
         {SFX_SHEEP,  2'd2}: n = '{per: 8'h20, dur: 4'd3};
         {SFX_SWORD,  2'd0}: n = '{per: 8'h18, dur: 4'd2};
         {SFX_SWORD,  2'd1}: n = '{per: 8'h10, dur: 4'd2};
         {SFX_SWORD,  2'd2}: n = '{per: 8'h18, dur: 4'd2};
         {SFX_SWORD,  2'd3}: n = '{per: 8'h10, dur: 4'd2};
         {SFX_PLAYER, 2'd0}: n = '{per: 8'h80, dur: 4'd4};
         {SFX_PLAYER, 2'd1}: n = '{per: 8'hA0, dur: 4'd4};
         {SFX_PLAYER, 2'd2}: n = '{per: 8'hC0, dur: 4'd8};
         default:            n = '{per: 8'h00, dur: 4'd0};
      endcase
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sfx_tick_divider.sv
// ============================================================================
//  Module   : sfx_tick_divider
//  Purpose  : CLK_DIV prescaler; tick on count zero, gated by en, sync reload.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sfx_tick_divider #(
   parameter int CLK_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic reload,
   output logic tick
);

   localparam int            CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] RELOAD_VAL = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (reload) begin
         cnt_d = RELOAD_VAL;
      end else if (en) begin
         if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = RELOAD_VAL;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= RELOAD_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sfx_sequencer.sv
// ============================================================================
//  Module   : sfx_sequencer
//  Purpose  : Turns collision edges into multi-note sound effects for the
//             sawtooth/PWM audio stage (period, decaying volume, gate).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sfx_sequencer
   import sfx_pkg::*;
#(
   parameter int CLK_DIV     = 100000,
   parameter int PERIOD_BITS = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sheep_hit,
   input  logic                   sword_hit,
   input  logic                   player_hit,
   output logic [PERIOD_BITS-1:0] period,
   output logic [3:0]             volume,
   output logic                   gate,
   output logic                   busy,
   output logic [1:0]             effect_id
);

   logic [2:0]             hit_q,       hit_d;
   sfx_state_t             state_q,     state_d;
   logic [1:0]             idx_q,       idx_d;
   logic [3:0]             rem_q,       rem_d;
   logic [3:0]             volume_q,    volume_d;
   logic                   gate_q,      gate_d;
   logic                   busy_q,      busy_d;
   logic [1:0]             effect_id_q, effect_id_d;
   logic [PERIOD_BITS-1:0] period_q,    period_d;

   logic                   tick;
   logic [2:0]             ev;
   logic [1:0]             ev_id;
   logic                   start;
   sfx_note_t              start_note;
   sfx_note_t              next_note;
   logic [PERIOD_BITS-1:0] start_per;
   logic [PERIOD_BITS-1:0] next_per;

   // Bit order: [2] player, [1] sword, [0] sheep.
   assign hit_d = {player_hit, sword_hit, sheep_hit};
   assign ev    = hit_d & ~hit_q;
   assign ev_id = ev[2] ? SFX_PLAYER :
                  ev[1] ? SFX_SWORD  :
                  ev[0] ? SFX_SHEEP  : SFX_NONE;
   assign start = (ev_id != SFX_NONE) && (ev_id >= effect_id_q);

   assign start_note = sfx_note(ev_id, 2'd0);
   assign next_note  = sfx_note(effect_id_q, idx_q + 2'd1);

   generate
      if (PERIOD_BITS >= 8) begin : g_per_zext
         assign start_per = PERIOD_BITS'(start_note.per);
         assign next_per  = PERIOD_BITS'(next_note.per);
      end else begin : g_per_msb
         assign start_per = start_note.per[7 -: PERIOD_BITS];
         assign next_per  = next_note.per[7 -: PERIOD_BITS];
      end
   endgenerate

   sfx_tick_divider #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_divider (
      .clk    (clk),
      .reset  (reset),
      .en     (busy_q),
      .reload (start),
      .tick   (tick)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      rem_d       = rem_q;
      volume_d    = volume_q;
      gate_d      = gate_q;
      busy_d      = busy_q;
      effect_id_d = effect_id_q;
      period_d    = period_q;

      // A start overrides whatever the tick would have done this cycle.
      if (start) begin
         state_d     = ST_PLAY;
         idx_d       = 2'd0;
         rem_d       = start_note.dur;
         period_d    = start_per;
         volume_d    = 4'd15;
         gate_d      = 1'b1;
         busy_d      = 1'b1;
         effect_id_d = ev_id;
      end else if (tick) begin
         case (state_q)
            ST_PLAY: begin
               volume_d = (volume_q == 4'd0) ? 4'd0 : volume_q - 4'd1;
               if (rem_q > 4'd1) begin
                  rem_d = rem_q - 4'd1;
               end else begin
                  state_d  = ST_GAP;
                  gate_d   = 1'b0;
                  volume_d = 4'd0;
               end
            end
            ST_GAP: begin
               idx_d = idx_q + 2'd1;
               if ((idx_q == 2'd3) || (next_note.dur == 4'd0)) begin
                  state_d     = ST_IDLE;
                  busy_d      = 1'b0;
                  effect_id_d = SFX_NONE;
               end else begin
                  state_d  = ST_PLAY;
                  period_d = next_per;
                  volume_d = 4'd15;
                  gate_d   = 1'b1;
                  rem_d    = next_note.dur;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hit_q       <= '0;
         state_q     <= ST_IDLE;
         idx_q       <= 2'd0;
         rem_q       <= 4'd0;
         volume_q    <= 4'd0;
         gate_q      <= 1'b0;
         busy_q      <= 1'b0;
         effect_id_q <= SFX_NONE;
         period_q    <= '0;
      end else begin
         hit_q       <= hit_d;
         state_q     <= state_d;
         idx_q       <= idx_d;
         rem_q       <= rem_d;
         volume_q    <= volume_d;
         gate_q      <= gate_d;
         busy_q      <= busy_d;
         effect_id_q <= effect_id_d;
         period_q    <= period_d;
      end
   end

   assign period    = period_q;
   assign volume    = volume_q;
   assign gate      = gate_q;
   assign busy      = busy_q;
   assign effect_id = effect_id_q;

endmodule

`default_nettype wire

// File: tb/tb_sfx_sequencer.sv
// ============================================================================
//  Module   : tb_sfx_sequencer
//  Purpose  : Directed vector bench for sfx_sequencer with CLK_DIV = 4.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sfx_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       sheep_hit;
   logic       sword_hit;
   logic       player_hit;
   logic [7:0] period;
   logic [3:0] volume;
   logic       gate;
   logic       busy;
   logic [1:0] effect_id;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic       sheep;
      logic       sword;
      logic       player;
      int         adv;
      logic [7:0] per;
      logic [3:0] vol;
      logic       gate;
      logic       busy;
      logic [1:0] eid;
   } vec_t;

   vec_t vecs[$];

   sfx_sequencer #(
      .CLK_DIV     (4),
      .PERIOD_BITS (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sheep_hit  (sheep_hit),
      .sword_hit  (sword_hit),
      .player_hit (player_hit),
      .period     (period),
      .volume     (volume),
      .gate       (gate),
      .busy       (busy),
      .effect_id  (effect_id)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic s, input logic w, input logic p,
                               input int a, input logic [7:0] pe,
                               input logic [3:0] v, input logic g,
                               input logic b, input logic [1:0] e);
      vec_t r;
      r.sheep = s; r.sword = w; r.player = p; r.adv = a;
      r.per = pe; r.vol = v; r.gate = g; r.busy = b; r.eid = e;
      return r;
   endfunction

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [7:0] e_per,
                           input logic [3:0] e_vol, input logic e_gate,
                           input logic e_busy, input logic [1:0] e_eid);
      cmp({tag, ".period"},    32'(period),    32'(e_per));
      cmp({tag, ".volume"},    32'(volume),    32'(e_vol));
      cmp({tag, ".gate"},      32'(gate),      32'(e_gate));
      cmp({tag, ".busy"},      32'(busy),      32'(e_busy));
      cmp({tag, ".effect_id"}, 32'(effect_id), 32'(e_eid));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Sheep effect; offsets below count edges after the start edge.
      //                    s  w  p  adv per    vol   g  b  id
      vecs.push_back(mk(1, 0, 0,  1, 8'h40, 4'd15, 1, 1, 2'd1)); // 0
      vecs.push_back(mk(0, 0, 0,  3, 8'h40, 4'd15, 1, 1, 2'd1)); // 3
      vecs.push_back(mk(0, 0, 0,  1, 8'h40, 4'd14, 1, 1, 2'd1)); // 4
      vecs.push_back(mk(0, 0, 0,  7, 8'h40, 4'd13, 1, 1, 2'd1)); // 11
      vecs.push_back(mk(0, 0, 0,  1, 8'h40, 4'd0,  0, 1, 2'd1)); // 12 gap
      vecs.push_back(mk(0, 0, 0,  3, 8'h40, 4'd0,  0, 1, 2'd1)); // 15
      vecs.push_back(mk(0, 0, 0,  1, 8'h30, 4'd15, 1, 1, 2'd1)); // 16
      vecs.push_back(mk(0, 0, 0, 16, 8'h20, 4'd15, 1, 1, 2'd1)); // 32
      vecs.push_back(mk(0, 0, 0, 12, 8'h20, 4'd0,  0, 1, 2'd1)); // 44
      vecs.push_back(mk(0, 0, 0,  3, 8'h20, 4'd0,  0, 1, 2'd1)); // 47
      vecs.push_back(mk(0, 0, 0,  1, 8'h20, 4'd0,  0, 0, 2'd0)); // 48 idle
      // Sword and player same cycle; later sheep edge is ignored.
      vecs.push_back(mk(0, 1, 1,  1, 8'h80, 4'd15, 1, 1, 2'd3)); // 0
      vecs.push_back(mk(1, 0, 0,  2, 8'h80, 4'd15, 1, 1, 2'd3)); // 2
      vecs.push_back(mk(0, 0, 0,  2, 8'h80, 4'd14, 1, 1, 2'd3)); // 4
      vecs.push_back(mk(0, 0, 0, 12, 8'h80, 4'd0,  0, 1, 2'd3)); // 16 gap
      vecs.push_back(mk(0, 0, 0,  4, 8'hA0, 4'd15, 1, 1, 2'd3)); // 20
      vecs.push_back(mk(0, 0, 0,  4, 8'hA0, 4'd14, 1, 1, 2'd3)); // 24
      // Player re-rise restarts at note 0 with the prescaler reloaded.
      vecs.push_back(mk(0, 0, 1,  1, 8'h80, 4'd15, 1, 1, 2'd3)); // 0
      vecs.push_back(mk(0, 0, 0,  3, 8'h80, 4'd15, 1, 1, 2'd3)); // 3
      vecs.push_back(mk(0, 0, 0,  1, 8'h80, 4'd14, 1, 1, 2'd3)); // 4
      vecs.push_back(mk(0, 0, 0, 36, 8'hC0, 4'd15, 1, 1, 2'd3)); // 40
      vecs.push_back(mk(0, 0, 0, 35, 8'hC0, 4'd0,  0, 1, 2'd3)); // 75
      vecs.push_back(mk(0, 0, 0,  1, 8'hC0, 4'd0,  0, 0, 2'd0)); // 76 idle
      // Sword held high: one 4-note effect, then retrigger on fall/rise.
      vecs.push_back(mk(0, 1, 0,  1, 8'h18, 4'd15, 1, 1, 2'd2)); // 0
      vecs.push_back(mk(0, 1, 0, 12, 8'h10, 4'd15, 1, 1, 2'd2)); // 12
      vecs.push_back(mk(0, 1, 0, 12, 8'h18, 4'd15, 1, 1, 2'd2)); // 24
      vecs.push_back(mk(0, 1, 0, 12, 8'h10, 4'd15, 1, 1, 2'd2)); // 36
      vecs.push_back(mk(0, 1, 0, 11, 8'h10, 4'd0,  0, 1, 2'd2)); // 47
      vecs.push_back(mk(0, 1, 0,  1, 8'h10, 4'd0,  0, 0, 2'd0)); // 48 idle
      vecs.push_back(mk(0, 1, 0, 10, 8'h10, 4'd0,  0, 0, 2'd0)); // still held
      vecs.push_back(mk(0, 0, 0,  1, 8'h10, 4'd0,  0, 0, 2'd0)); // fall
      vecs.push_back(mk(0, 1, 0,  1, 8'h18, 4'd15, 1, 1, 2'd2)); // rise

      reset      = 1'b1;
      sheep_hit  = 1'b0;
      sword_hit  = 1'b0;
      player_hit = 1'b0;
      adv(3);
      chk_outs("reset", 8'h00, 4'd0, 1'b0, 1'b0, 2'd0);
      reset = 1'b0;
      adv(50);
      chk_outs("idle50", 8'h00, 4'd0, 1'b0, 1'b0, 2'd0);

      foreach (vecs[i]) begin
         sheep_hit  = vecs[i].sheep;
         sword_hit  = vecs[i].sword;
         player_hit = vecs[i].player;
         adv(vecs[i].adv);
         chk_outs($sformatf("vec%0d", i), vecs[i].per, vecs[i].vol,
                  vecs[i].gate, vecs[i].busy, vecs[i].eid);
      end

      // Reset during the first gap of a player effect, player_hit kept high.
      sword_hit = 1'b0;
      reset     = 1'b1;
      adv(2);
      reset = 1'b0;
      adv(1);
      chk_outs("rst_clear", 8'h00, 4'd0, 1'b0, 1'b0, 2'd0);
      player_hit = 1'b1;
      adv(1);
      chk_outs("pl_start", 8'h80, 4'd15, 1'b1, 1'b1, 2'd3);
      adv(17);
      chk_outs("pl_gap", 8'h80, 4'd0, 1'b0, 1'b1, 2'd3);
      reset = 1'b1;
      adv(1);
      chk_outs("gap_rst", 8'h00, 4'd0, 1'b0, 1'b0, 2'd0);
      adv(2);
      chk_outs("gap_rst_hold", 8'h00, 4'd0, 1'b0, 1'b0, 2'd0);
      reset = 1'b0;
      adv(1);
      chk_outs("post_rst_start", 8'h80, 4'd15, 1'b1, 1'b1, 2'd3);
      adv(4);
      chk_outs("post_rst_run", 8'h80, 4'd14, 1'b1, 1'b1, 2'd3);
      player_hit = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
